// File: rtl/program_ram_pkg.sv
// Shared definitions for the program RAM and its neighbours (MAR, main bus).
// Holds the default address/data widths and the loader FSM state encoding.
package program_ram_pkg;

  localparam int ADDRESS_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/program_ram_if.sv
// Bus/handshake bundle between the CPU + loader side and the program RAM.
//   master : drives address, bus data, run-mode strobes and loader stream
//   slave  : the RAM; returns read data, drive select and loader status
interface program_ram_if #(
  parameter int ADDRESS_WIDTH = program_ram_pkg::ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = program_ram_pkg::DATA_WIDTH_DEF
);
  logic [ADDRESS_WIDTH-1:0] i_ADDRESS;
  logic [DATA_WIDTH-1:0]    i_BUS;
  logic                     i_WRITE_BUS;
  logic                     i_OUTPUT;
  logic [DATA_WIDTH-1:0]    o_DATA;
  logic                     o_DRIVE;
  logic                     i_PROG_MODE;
  logic                     i_PROG_START;
  logic                     i_PROG_VALID;
  logic [DATA_WIDTH-1:0]    i_PROG_DATA;
  logic                     o_PROG_READY;
  logic                     o_PROG_DONE;
  logic                     o_BUSY;

  modport master (
    output i_ADDRESS, i_BUS, i_WRITE_BUS, i_OUTPUT,
    output i_PROG_MODE, i_PROG_START, i_PROG_VALID, i_PROG_DATA,
    input  o_DATA, o_DRIVE, o_PROG_READY, o_PROG_DONE, o_BUSY
  );

  modport slave (
    input  i_ADDRESS, i_BUS, i_WRITE_BUS, i_OUTPUT,
    input  i_PROG_MODE, i_PROG_START, i_PROG_VALID, i_PROG_DATA,
    output o_DATA, o_DRIVE, o_PROG_READY, o_PROG_DONE, o_BUSY
  );
endinterface

// File: rtl/program_ram_ram_array.sv
// Storage array: one synchronous write port, one asynchronous read port.
// No reset -- contents survive i_CLEAR.
//   clk/we/waddr/wdata : write port
//   raddr/rdata        : combinational read port
module ram_array #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Async read returns the pre-edge word, giving read-before-write.
  assign rdata = mem[raddr];
endmodule

// File: rtl/program_ram.sv
// Main CPU program RAM.
//   i_CLOCK : clock, rising edge
//   i_CLEAR : synchronous active-high reset (FSM/pointer only, not memory)
//   bus     : program_ram_if slave -- run-mode read/write from MAR + bus,
//             and the program-mode valid/ready loader stream.
// Run mode: combinational read gated onto o_DATA, bus write at the edge.
// Program mode: loader FSM fills addresses 0..depth-1; CPU access blocked.
module program_ram
  import program_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic         i_CLOCK,
  input  logic         i_CLEAR,
  program_ram_if.slave bus
);
  load_state_e              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     hs;

  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     drive;

  // Handshake only counts while loading in program mode; a word offered on
  // the abort cycle is dropped along with the load.
  assign hs = (state_q == ST_LOAD) && bus.i_PROG_MODE && bus.i_PROG_VALID;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_PROG_MODE && bus.i_PROG_START) begin
          ptr_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!bus.i_PROG_MODE) begin
          state_d = ST_IDLE;
        end else if (hs) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == {ADDRESS_WIDTH{1'b1}}) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.i_PROG_MODE) begin
          state_d = ST_IDLE;
        end else if (bus.i_PROG_START) begin
          ptr_d   = '0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered copies of the next state.
    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d == ST_LOAD);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge i_CLOCK) begin
    if (i_CLEAR) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Single write port: mode picks the owner, so no arbitration. Reset wins
  // over any write in the same cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.i_ADDRESS;
    mem_wdata = bus.i_BUS;
    if (bus.i_PROG_MODE) begin
      mem_we    = hs;
      mem_waddr = ptr_q;
      mem_wdata = bus.i_PROG_DATA;
    end else begin
      mem_we    = bus.i_WRITE_BUS;
    end
    if (i_CLEAR) mem_we = 1'b0;
  end

  ram_array #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk   (i_CLOCK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (bus.i_ADDRESS),
    .rdata (mem_rdata)
  );

  assign drive            = bus.i_OUTPUT && !bus.i_PROG_MODE;
  assign bus.o_DRIVE      = drive;
  assign bus.o_DATA       = drive ? mem_rdata : '0;
  assign bus.o_PROG_READY = ready_q;
  assign bus.o_PROG_DONE  = done_q;
  assign bus.o_BUSY       = busy_q;
endmodule

// File: tb/tb_program_ram.sv
module tb_program_ram;
  logic clk = 1'b0;
  logic clr;
  int   n_chk = 0;
  int   n_fail = 0;

  program_ram_if #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) ifc ();

  program_ram #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut (
    .i_CLOCK (clk),
    .i_CLEAR (clr),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] bus;
    logic       wr;
    logic       oe;
    logic       pm;
    logic [7:0] exp_data;
    logic       exp_drive;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic start_load();
    ifc.i_PROG_MODE  = 1'b1;
    ifc.i_OUTPUT     = 1'b0;
    ifc.i_WRITE_BUS  = 1'b0;
    ifc.i_PROG_START = 1'b1;
    cyc();
    ifc.i_PROG_START = 1'b0;
  endtask

  task automatic send_words(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      ifc.i_PROG_VALID = 1'b1;
      ifc.i_PROG_DATA  = base + 8'(k);
      cyc();
    end
    ifc.i_PROG_VALID = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string nm);
    ifc.i_PROG_MODE = 1'b0;
    ifc.i_WRITE_BUS = 1'b0;
    ifc.i_OUTPUT    = 1'b1;
    ifc.i_ADDRESS   = a;
    #2;
    chk(nm, 32'(ifc.o_DATA), 32'(exp));
    cyc();
  endtask

  task automatic chk_status(input string nm, input logic rdy, input logic bsy, input logic dn);
    #2;
    chk({nm, ".ready"}, 32'(ifc.o_PROG_READY), 32'(rdy));
    chk({nm, ".busy"},  32'(ifc.o_BUSY),       32'(bsy));
    chk({nm, ".done"},  32'(ifc.o_PROG_DONE),  32'(dn));
  endtask

  initial begin
    // Run-mode vectors, applied after the full 0x10.. load and the
    // backpressure load (mem[0]=B0, mem[1]=B1, mem[2..15]=0x12..0x1F).
    vecs[0] = '{4'd3,  8'hA5, 1'b1, 1'b1, 1'b0, 8'h13, 1'b1}; // old word same cycle
    vecs[1] = '{4'd3,  8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1}; // new word next cycle
    vecs[2] = '{4'd3,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}; // not driving -> 0
    vecs[3] = '{4'd9,  8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{4'd9,  8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1};
    vecs[5] = '{4'd7,  8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0}; // program-mode isolation
    vecs[6] = '{4'd7,  8'h00, 1'b0, 1'b1, 1'b0, 8'h17, 1'b1}; // mem[7] untouched
    vecs[7] = '{4'd15, 8'h00, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b1};
    vecs[8] = '{4'd0,  8'h00, 1'b0, 1'b1, 1'b0, 8'hB0, 1'b1};

    clr              = 1'b1;
    ifc.i_ADDRESS    = '0;
    ifc.i_BUS        = '0;
    ifc.i_WRITE_BUS  = 1'b0;
    ifc.i_OUTPUT     = 1'b0;
    ifc.i_PROG_MODE  = 1'b0;
    ifc.i_PROG_START = 1'b0;
    ifc.i_PROG_VALID = 1'b0;
    ifc.i_PROG_DATA  = '0;
    cyc(); cyc();
    clr = 1'b0;
    chk_status("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.drive", 32'(ifc.o_DRIVE), 32'd0);
    chk("reset.data",  32'(ifc.o_DATA),  32'd0);

    // Full load 0x10..0x1F with VALID held high.
    cyc();
    start_load();
    chk_status("load.start", 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      ifc.i_PROG_VALID = 1'b1;
      ifc.i_PROG_DATA  = 8'h10 + 8'(k);
      #2;
      chk($sformatf("load.ready%0d", k), 32'(ifc.o_PROG_READY), 32'd1);
      chk($sformatf("load.done%0d", k),  32'(ifc.o_PROG_DONE),  32'd0);
      cyc();
    end
    ifc.i_PROG_VALID = 1'b0;
    chk_status("load.end", 1'b0, 1'b0, 1'b1);
    rd(4'd5, 8'h15, "load.rd5");
    chk("load.rd_drive", 32'(ifc.o_DRIVE), 32'd1);

    // Backpressure: VALID 1,0,1,0.
    start_load();
    ifc.i_PROG_VALID = 1'b1; ifc.i_PROG_DATA = 8'hB0; cyc();
    ifc.i_PROG_VALID = 1'b0; ifc.i_PROG_DATA = 8'hEE; cyc();
    ifc.i_PROG_VALID = 1'b1; ifc.i_PROG_DATA = 8'hB1; cyc();
    ifc.i_PROG_VALID = 1'b0; ifc.i_PROG_DATA = 8'hEE; cyc();
    chk_status("bp.loading", 1'b1, 1'b1, 1'b0);
    rd(4'd0, 8'hB0, "bp.rd0");
    rd(4'd1, 8'hB1, "bp.rd1");
    rd(4'd2, 8'h12, "bp.rd2");

    // Run-mode table.
    for (int i = 0; i < 9; i++) begin
      ifc.i_ADDRESS   = vecs[i].addr;
      ifc.i_BUS       = vecs[i].bus;
      ifc.i_WRITE_BUS = vecs[i].wr;
      ifc.i_OUTPUT    = vecs[i].oe;
      ifc.i_PROG_MODE = vecs[i].pm;
      #2;
      chk($sformatf("vec%0d.data", i),  32'(ifc.o_DATA),  32'(vecs[i].exp_data));
      chk($sformatf("vec%0d.drive", i), 32'(ifc.o_DRIVE), 32'(vecs[i].exp_drive));
      cyc();
    end
    ifc.i_WRITE_BUS = 1'b0;

    // Abort after 4 words, then reload from 0.
    start_load();
    send_words(8'h40, 4);
    ifc.i_PROG_MODE = 1'b0;
    cyc();
    chk_status("abort", 1'b0, 1'b0, 1'b0);
    start_load();
    send_words(8'h50, 1);
    rd(4'd0, 8'h50, "abort.rd0");
    rd(4'd1, 8'h41, "abort.rd1");
    rd(4'd2, 8'h42, "abort.rd2");
    rd(4'd3, 8'h43, "abort.rd3");
    rd(4'd4, 8'h14, "abort.rd4");
    rd(4'd9, 8'h3C, "abort.rd9");

    // Reset mid-load after 6 words; the word offered with CLEAR is dropped.
    start_load();
    send_words(8'h60, 6);
    clr = 1'b1;
    ifc.i_PROG_VALID = 1'b1;
    ifc.i_PROG_DATA  = 8'h66;
    cyc();
    clr = 1'b0;
    ifc.i_PROG_VALID = 1'b0;
    chk_status("midrst", 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      rd(4'(k), 8'h60 + 8'(k), $sformatf("midrst.rd%0d", k));
    rd(4'd6, 8'h16, "midrst.rd6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
